note_sequencer: RTL and testbench

- Plays a programmed sequence of notes by driving the frequency_control input of the square_wave generator, plus a gate that mutes its output between notes and during rests.
- Holds a small note table (frequency code + duration per entry), written by the host. Steps through it on a tick timebase with start/stop/loop control and busy/done status.
- Sits between host/control logic and square_wave: frequency_control connects directly to square_wave; gate qualifies square_out downstream.

---
 rtl/sound_pkg.sv | 21 ++
 rtl/tick_gen.sv | 38 +++
 rtl/note_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Types and constants shared by the sound blocks (note_sequencer, square_wave, envelopes).
package sound_pkg;

  localparam int FREQ_W     = 8;
  localparam int NOTE_DUR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  // Default-width note entry; the sequencer re-declares it with its own DUR_W.
  typedef struct packed {
    logic [FREQ_W-1:0]     freq;
    logic [NOTE_DUR_W-1:0] dur;
  } note_t;

endpackage

// File: rtl/tick_gen.sv
// TICK_DIV prescaler: one-cycle tick every TICK_DIV enabled cycles, with synchronous clear.
module tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps a host-written table of {freq, dur} entries on a tick timebase,
// driving square_wave's frequency_control and a gate that mutes between notes.
module note_sequencer
  import sound_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [FREQ_W-1:0]          wr_freq,
  input  logic [DUR_W-1:0]           wr_dur,
  output logic [FREQ_W-1:0]          frequency_control,
  output logic                       gate,
  output logic [$clog2(DEPTH)-1:0]   note_index,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t cur;

  seq_state_e        state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              gate_q, gate_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, adv, to_done;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(reset),
    .clr  (state_q == ST_LOAD),
    .en   ((state_q == ST_PLAY) || (state_q == ST_GAP)),
    .tick (tick)
  );

  // The table only accepts writes while idle, so playback never sees a half-edited sequence.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !busy_q) begin
      mem_d[wr_addr].freq = wr_freq;
      mem_d[wr_addr].dur  = wr_dur;
    end
  end

  // NOTE: the table is reset like any other state so a reset always leaves an empty sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    gate_d  = gate_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    to_done = 1'b0;
    cur     = mem_q[idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cur.dur != '0) begin
          freq_d  = cur.freq;
          gate_d  = (cur.freq != '0);
          dur_d   = cur.dur;
          state_d = ST_PLAY;
        end else if (idx_q != '0 && loop_en) begin
          idx_d = '0;
        end else begin
          to_done = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            if (GAP_TICKS != 0) begin
              state_d = ST_GAP;
              gate_d  = 1'b0;
              dur_d   = DUR_W'(GAP_TICKS);
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          dur_d = dur_q - DUR_W'(1);
          adv   = (dur_q == DUR_W'(1));
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (adv) begin
      if (idx_q != LAST_IDX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_LOAD;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end else begin
        to_done = 1'b1;
      end
    end

    if (to_done) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      freq_d  = '0;
      gate_d  = 1'b0;
    end

    // Abort silences immediately and suppresses the done pulse.
    if (stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      freq_d  = '0;
      gate_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      freq_q  <= '0;
      gate_q  <= 1'b0;
      idx_q   <= '0;
      dur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      gate_q  <= gate_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign frequency_control = freq_q;
  assign gate              = gate_q;
  assign note_index        = idx_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: per-cycle vector table plus model-generated traces.
module tb_note_sequencer;

  localparam int DEPTH     = 16;
  localparam int DUR_W     = 8;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [3:0]       wr_addr = '0;
  logic [7:0]       wr_freq = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [7:0]       frequency_control;
  logic             gate;
  logic [3:0]       note_index;
  logic             busy, done;

  int checks = 0;
  int failures = 0;

  note_sequencer #(
    .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_dur(wr_dur),
    .frequency_control(frequency_control), .gate(gate), .note_index(note_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] freq;
    logic       gate;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic       st, sp, we;
    logic [3:0] wa;
    logic [7:0] wf, wd;
    obs_t       exp;
  } vec_t;

  function automatic obs_t mk(input int f, input int g, input int i, input int b, input int d);
    obs_t o;
    o.freq = f[7:0];
    o.gate = g[0];
    o.idx  = i[3:0];
    o.busy = b[0];
    o.done = d[0];
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {frequency_control, gate, note_index, busy, done};
    return o;
  endfunction

  function automatic vec_t v(input int st, input int sp, input int we, input int wa,
                             input int wf, input int wd, input obs_t e);
    vec_t r;
    r.st = st[0]; r.sp = sp[0]; r.we = we[0];
    r.wa = wa[3:0]; r.wf = wf[7:0]; r.wd = wd[7:0];
    r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input int step, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got freq=%0d gate=%b idx=%0d busy=%b done=%b, expected freq=%0d gate=%b idx=%0d busy=%b done=%b",
               name, step, got.freq, got.gate, got.idx, got.busy, got.done,
               exp.freq, exp.gate, exp.idx, exp.busy, exp.done);
    end
  endtask

  // Reference model: note table contents and the expected per-cycle output trace.
  int   nf [DEPTH];
  int   nd [DEPTH];
  obs_t expq [$];
  int   clear_at;

  // Expands the table into cycles: LOAD, dur*TICK_DIV PLAY, GAP_TICKS*TICK_DIV GAP per note,
  // an end-marker LOAD (unless the table is full), then DONE and IDLE.
  task automatic build(input int len, input int passes);
    int f_prev;
    int last;
    f_prev = 0;
    expq.delete();
    clear_at = 0;
    if (len == 0) begin
      expq.push_back(mk(0, 0, 0, 1, 0));
      expq.push_back(mk(0, 0, 0, 1, 1));
      expq.push_back(mk(0, 0, 0, 0, 0));
      return;
    end
    for (int p = 0; p < passes; p++) begin
      if (p == passes - 1) clear_at = expq.size();
      for (int k = 0; k < len; k++) begin
        expq.push_back(mk(f_prev, 0, k, 1, 0));
        for (int c = 0; c < nd[k] * TICK_DIV; c++) expq.push_back(mk(nf[k], nf[k] != 0, k, 1, 0));
        for (int c = 0; c < GAP_TICKS * TICK_DIV; c++) expq.push_back(mk(nf[k], 0, k, 1, 0));
        f_prev = nf[k];
      end
      if (len < DEPTH) expq.push_back(mk(f_prev, 0, len, 1, 0));
    end
    last = (len < DEPTH) ? len : DEPTH - 1;
    expq.push_back(mk(0, 0, last, 1, 1));
    expq.push_back(mk(0, 0, last, 0, 0));
  endtask

  task automatic write_entry(input int a, input int f, input int d);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_freq = f[7:0]; wr_dur = d[DUR_W-1:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_table(input int len);
    for (int k = 0; k < len; k++) write_entry(k, nf[k], nd[k]);
    if (len < DEPTH) write_entry(len, 0, 0);
  endtask

  task automatic run_trace(input string name, input logic lp);
    loop_en = lp;
    start = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check(name, i, sample(), expq[i]);
      if (i == clear_at) loop_en = 1'b0;
    end
    loop_en = 1'b0;
  endtask

  vec_t vecs [22];

  initial begin
    int len;
    int passes;

    // Cycle-by-cycle vectors from a freshly reset (empty) table.
    vecs[0]  = v(1, 1, 0, 0, 0,  0, mk(0,  0, 0, 0, 0));  // start+stop in IDLE: stop wins
    vecs[1]  = v(1, 0, 0, 0, 0,  0, mk(0,  0, 0, 1, 0));  // LOAD of empty entry 0
    vecs[2]  = v(0, 0, 0, 0, 0,  0, mk(0,  0, 0, 1, 1));  // done at start+2
    vecs[3]  = v(0, 0, 0, 0, 0,  0, mk(0,  0, 0, 0, 0));  // idle at start+3
    vecs[4]  = v(0, 0, 1, 0, 50, 1, mk(0,  0, 0, 0, 0));
    vecs[5]  = v(1, 0, 0, 0, 0,  0, mk(0,  0, 0, 1, 0));
    vecs[6]  = v(0, 0, 1, 0, 99, 5, mk(50, 1, 0, 1, 0));  // write while busy is dropped
    vecs[7]  = v(1, 0, 0, 0, 0,  0, mk(50, 1, 0, 1, 0));  // start while busy is ignored
    vecs[8]  = v(0, 0, 0, 0, 0,  0, mk(50, 1, 0, 1, 0));
    vecs[9]  = v(0, 0, 0, 0, 0,  0, mk(50, 1, 0, 1, 0));
    vecs[10] = v(0, 0, 0, 0, 0,  0, mk(50, 0, 0, 1, 0));
    vecs[11] = v(0, 0, 0, 0, 0,  0, mk(50, 0, 0, 1, 0));
    vecs[12] = v(0, 0, 0, 0, 0,  0, mk(50, 0, 0, 1, 0));
    vecs[13] = v(0, 0, 0, 0, 0,  0, mk(50, 0, 0, 1, 0));
    vecs[14] = v(0, 0, 0, 0, 0,  0, mk(50, 0, 1, 1, 0));
    vecs[15] = v(0, 0, 0, 0, 0,  0, mk(0,  0, 1, 1, 1));
    vecs[16] = v(0, 0, 0, 0, 0,  0, mk(0,  0, 1, 0, 0));
    vecs[17] = v(1, 0, 0, 0, 0,  0, mk(0,  0, 0, 1, 0));
    vecs[18] = v(0, 0, 0, 0, 0,  0, mk(50, 1, 0, 1, 0));  // table still holds {50,1}
    vecs[19] = v(0, 0, 0, 0, 0,  0, mk(50, 1, 0, 1, 0));
    vecs[20] = v(0, 1, 0, 0, 0,  0, mk(0,  0, 0, 0, 0));  // stop in second PLAY cycle
    vecs[21] = v(0, 0, 0, 0, 0,  0, mk(0,  0, 0, 0, 0));  // no done after stop

    #12;
    check("reset_state", 0, sample(), mk(0, 0, 0, 0, 0));
    #10 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].st; stop = vecs[i].sp; wr_en = vecs[i].we;
      wr_addr = vecs[i].wa; wr_freq = vecs[i].wf; wr_dur = vecs[i].wd;
      @(posedge clk); #1;
      check("vector", i, sample(), vecs[i].exp);
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;

    nf[0] = 20; nd[0] = 2; nf[1] = 40; nd[1] = 1;
    load_table(2); build(2, 1); run_trace("basic", 1'b0);

    nf[0] = 0; nd[0] = 1; nf[1] = 30; nd[1] = 1;
    load_table(2); build(2, 1); run_trace("rest", 1'b0);

    nf[0] = 10; nd[0] = 1;
    load_table(1); build(1, 3); run_trace("loop", 1'b1);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 5);
      passes = $urandom_range(1, 2);
      for (int k = 0; k < len; k++) begin
        nf[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
        nd[k] = $urandom_range(1, 3);
      end
      load_table(len); build(len, passes); run_trace("random", passes > 1);
    end

    for (int k = 0; k < DEPTH; k++) begin
      nf[k] = k + 1; nd[k] = 1;
    end
    load_table(DEPTH); build(DEPTH, 1); run_trace("full_table", 1'b0);

    // Asynchronous reset in the middle of a note, checked between clock edges.
    nf[0] = 20; nd[0] = 3;
    load_table(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_reset", 0, sample(), mk(20, 1, 0, 1, 0));
    #2 reset = 1'b0;
    #1 check("async_reset", 0, sample(), mk(0, 0, 0, 0, 0));
    #3 reset = 1'b1;
    @(posedge clk); #1;
    build(0, 1); run_trace("cleared_table", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
